muldiv_iter: RTL and testbench

Parametrised multi-cycle multiply/divide unit for the EXE stage. It replaces the fixed-latency vendor multiplier and the AXI-stream divider with one block that has an explicit start/busy/done handshake, a flush cancel, and configurable width and multiply latency. It drives the HI/LO results that EXE forwards to MEM. It holds no architectural HI/LO state; the register file still owns that.

---
 rtl/muldiv_iter_if.sv | 15 +
 rtl/muldiv_iter.sv | 175 +++++++++++++++++
 tb/tb_muldiv_iter.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_iter_if.sv
// Request/response bundle between the EXE stage and the multiply/divide unit.
interface muldiv_iter_if #(parameter int WIDTH = 32);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] src1;
  logic [WIDTH-1:0] src2;
  logic             cancel;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (output start, op, src1, src2, cancel, input busy, done, hi, lo);
  modport slave  (input start, op, src1, src2, cancel, output busy, done, hi, lo);
endinterface

// File: rtl/muldiv_iter.sv
// Iterative MULT/MULTU/DIV/DIVU unit with start/busy/done handshake and flush.
// Define MULDIV_DIV_EN to build the restoring divider; otherwise DIV ops finish at once with zero results.
module muldiv_iter #(
  parameter int WIDTH   = 32,
  parameter int MUL_LAT = 2
) (
  input  logic          clk,
  input  logic          resetn,
  muldiv_iter_if.slave  bus
);
  localparam int CW = ($clog2(WIDTH + 1) > 4) ? $clog2(WIDTH + 1) : 4;
  localparam logic [CW-1:0] LAT_C = CW'(MUL_LAT);

  typedef enum logic [2:0] {IDLE, MUL, DIV, FIX, DONE} state_t;

  state_t              state, nxt;
  logic [CW-1:0]       cnt;
  logic                accept, ld_mul;
  logic signed [WIDTH:0]     ax, bx;
  logic signed [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0]  mul_res;
  logic [WIDTH-1:0]    hi_q, lo_q;
  logic                sgn;

  assign sgn = ~bus.op[0];

`ifdef MULDIV_DIV_EN
  localparam logic [CW-1:0] DIV_C = CW'(WIDTH);
  logic                ld_fix;
  logic [WIDTH-1:0]    quo, rem, dvs, s1_q;
  logic                q_neg, r_neg;
  logic [WIDTH-1:0]    abs1, abs2, rem_nxt;
  logic [WIDTH:0]      shl, diff;
  logic                ge;

  assign abs1 = (sgn & bus.src1[WIDTH-1]) ? -bus.src1 : bus.src1;
  assign abs2 = (sgn & bus.src2[WIDTH-1]) ? -bus.src2 : bus.src2;
  // remainder < divisor, so a borrow out of the top bit means "does not fit"
  assign shl     = {rem, quo[WIDTH-1]};
  assign diff    = shl - {1'b0, dvs};
  assign ge      = ~diff[WIDTH];
  assign rem_nxt = ge ? diff[WIDTH-1:0] : shl[WIDTH-1:0];
`endif

  // Low 2W bits of the (W+1)-bit signed product are the same for both signednesses.
  assign prod = ax * bx;

  generate
    if (MUL_LAT == 1) begin : g_lat1
      assign mul_res = prod;
    end else begin : g_pipe
      logic [MUL_LAT-2:0][2*WIDTH-1:0] pipe;
      always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) pipe <= '0;
        else begin
          pipe[0] <= prod;
          for (int k = 1; k < MUL_LAT - 1; k++) pipe[k] <= pipe[k-1];
        end
      end
      assign mul_res = pipe[MUL_LAT-2];
    end
  endgenerate

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= nxt;
  end

  always_comb begin
    nxt    = state;
    accept = 1'b0;
    ld_mul = 1'b0;
`ifdef MULDIV_DIV_EN
    ld_fix = 1'b0;
`endif
    case (state)
      IDLE, DONE: begin
        nxt = IDLE;
        if (bus.start) begin
          accept = 1'b1;
`ifdef MULDIV_DIV_EN
          nxt = bus.op[1] ? DIV : MUL;
`else
          nxt = bus.op[1] ? DONE : MUL;
`endif
        end
      end
      MUL: if (cnt == LAT_C) begin
        ld_mul = 1'b1;
        nxt    = DONE;
      end
`ifdef MULDIV_DIV_EN
      DIV: if (cnt == DIV_C) nxt = FIX;
      FIX: begin
        ld_fix = 1'b1;
        nxt    = DONE;
      end
`endif
      default: nxt = IDLE;
    endcase
    if (bus.cancel) begin
      nxt    = IDLE;
      accept = 1'b0;
      ld_mul = 1'b0;
`ifdef MULDIV_DIV_EN
      ld_fix = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt  <= '0;
      ax   <= '0;
      bx   <= '0;
      hi_q <= '0;
      lo_q <= '0;
`ifdef MULDIV_DIV_EN
      quo   <= '0;
      rem   <= '0;
      dvs   <= '0;
      s1_q  <= '0;
      q_neg <= 1'b0;
      r_neg <= 1'b0;
`endif
    end else begin
      if (accept) begin
        cnt <= CW'(1);
        ax  <= {sgn & bus.src1[WIDTH-1], bus.src1};
        bx  <= {sgn & bus.src2[WIDTH-1], bus.src2};
`ifdef MULDIV_DIV_EN
        quo   <= abs1;
        dvs   <= abs2;
        rem   <= '0;
        s1_q  <= bus.src1;
        q_neg <= sgn & (bus.src1[WIDTH-1] ^ bus.src2[WIDTH-1]);
        r_neg <= sgn & bus.src1[WIDTH-1];
`endif
      end else if (state == MUL || state == DIV) begin
        cnt <= cnt + CW'(1);
      end
`ifdef MULDIV_DIV_EN
      if (state == DIV) begin
        rem <= rem_nxt;
        quo <= {quo[WIDTH-2:0], ge};
      end
`endif
      if (ld_mul) begin
        hi_q <= mul_res[2*WIDTH-1:WIDTH];
        lo_q <= mul_res[WIDTH-1:0];
      end
`ifdef MULDIV_DIV_EN
      if (ld_fix) begin
        if (dvs == '0) begin
          lo_q <= '1;
          hi_q <= s1_q;
        end else begin
          lo_q <= q_neg ? -quo : quo;
          hi_q <= r_neg ? -rem : rem;
        end
      end
`else
      if (accept && bus.op[1]) begin
        hi_q <= '0;
        lo_q <= '0;
      end
`endif
    end
  end

  assign bus.busy = (state == MUL) || (state == DIV) || (state == FIX);
  assign bus.done = (state == DONE);
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;
endmodule

// File: tb/tb_muldiv_iter.sv
// Scoreboard bench for muldiv_iter: directed vectors, monitor checks result and done cycle.
module tb_muldiv_iter;
  localparam int W = 32;
  localparam logic [1:0] MULT = 2'b00, MULTU = 2'b01, DIVS = 2'b10, DIVU = 2'b11;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    int           due;
    string        nm;
  } exp_t;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;
  logic [W-1:0] last_hi = '0, last_lo = '0;
  exp_t exp_q[$];

  muldiv_iter_if #(.WIDTH(W)) bus ();
  muldiv_iter #(.WIDTH(W), .MUL_LAT(2)) dut (.clk(clk), .resetn(resetn), .bus(bus));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] want);
    n_cmp++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", nm, act, want);
    end
  endtask

  // monitor: every done pulse must match the head of the scoreboard, including its cycle
  always @(negedge clk) begin
    if (resetn && bus.done) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_done: hi=%h lo=%h at cycle %0d, want no done", bus.hi, bus.lo, cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (bus.hi !== e.hi || bus.lo !== e.lo || cyc != e.due) begin
          n_err++;
          $display("FAIL %s: hi=%h lo=%h cycle=%0d, want hi=%h lo=%h cycle=%0d",
                   e.nm, bus.hi, bus.lo, cyc, e.hi, e.lo, e.due);
        end
      end
    end
  end

  // call at a negedge with the unit not busy
  task automatic start_op(input string nm, input logic [1:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [W-1:0] ehi,
                          input logic [W-1:0] elo, input int lat);
    exp_t e;
    bus.op = op; bus.src1 = a; bus.src2 = b; bus.start = 1'b1;
    e.hi = ehi; e.lo = elo; e.due = cyc + 1 + lat; e.nm = nm;
    exp_q.push_back(e);
    last_hi = ehi; last_lo = elo;
    @(posedge clk); #1 bus.start = 1'b0;
  endtask

  task automatic kick(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    bus.op = op; bus.src1 = a; bus.src2 = b; bus.start = 1'b1;
    @(posedge clk); #1 bus.start = 1'b0;
  endtask

  task automatic drain(input string nm);
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 100) begin
      @(negedge clk); t++;
    end
    if (exp_q.size() != 0) begin
      n_cmp++; n_err++;
      $display("FAIL %s_timeout: %0d results pending, want 0", nm, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic mul(input string nm, input logic [1:0] op, input logic [W-1:0] a,
                     input logic [W-1:0] b, input logic [W-1:0] ehi, input logic [W-1:0] elo);
    start_op(nm, op, a, b, ehi, elo, 2);
    drain(nm);
  endtask

  task automatic div(input string nm, input logic [1:0] op, input logic [W-1:0] a,
                     input logic [W-1:0] b, input logic [W-1:0] ehi, input logic [W-1:0] elo);
`ifdef MULDIV_DIV_EN
    start_op(nm, op, a, b, ehi, elo, W + 1);
`else
    start_op(nm, op, a, b, '0, '0, 0);
`endif
    drain(nm);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int t;
    bus.start = 1'b0; bus.op = 2'b00; bus.src1 = '0; bus.src2 = '0; bus.cancel = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", W'(bus.busy), '0);
    chk("rst_done", W'(bus.done), '0);
    chk("rst_hi", bus.hi, '0);
    chk("rst_lo", bus.lo, '0);
    resetn = 1'b1;
    @(negedge clk);

    mul("mult_neg1x2",  MULT,  32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFE);
    mul("multu_maxx2",  MULTU, 32'hFFFFFFFF, 32'h00000002, 32'h00000001, 32'hFFFFFFFE);
    mul("mult_minxmin", MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000);
    mul("multu_maxsq",  MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
    mul("mult_xneg1",   MULT,  32'h00012345, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFEDCBB);

    div("div_m7_2",     DIVS, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD);
    div("divu_7_2",     DIVU, 32'h00000007, 32'h00000002, 32'h00000001, 32'h00000003);
    div("div_7_m2",     DIVS, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD);
    div("div_ovf",      DIVS, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000);
    div("divu_max_16",  DIVU, 32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 32'h0FFFFFFF);
    div("div_m5_0",     DIVS, 32'hFFFFFFFB, 32'h00000000, 32'hFFFFFFFB, 32'hFFFFFFFF);
    div("divu_9_3",     DIVU, 32'h00000009, 32'h00000003, 32'h00000000, 32'h00000003);
    div("divu_5_0",     DIVU, 32'h00000005, 32'h00000000, 32'h00000005, 32'hFFFFFFFF);

    // cancel mid-operation; a start raised while busy must be ignored
`ifdef MULDIV_DIV_EN
    kick(DIVS, 32'd100, 32'd7);
    @(negedge clk);
    chk("busy_after_start", W'(bus.busy), W'(1));
    repeat (2) @(negedge clk);
    bus.op = MULT; bus.src1 = 32'd3; bus.src2 = 32'd4; bus.start = 1'b1;
    repeat (3) @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    bus.cancel = 1'b1;
`else
    kick(MULT, 32'd3, 32'd4);
    @(negedge clk);
    chk("busy_after_start", W'(bus.busy), W'(1));
    bus.op = MULTU; bus.start = 1'b1; bus.cancel = 1'b1;
`endif
    @(negedge clk);
    bus.cancel = 1'b0; bus.start = 1'b0;
    chk("busy_after_cancel", W'(bus.busy), '0);
    repeat (40) @(negedge clk);
    chk("cancel_hi_hold", bus.hi, last_hi);
    chk("cancel_lo_hold", bus.lo, last_lo);

    // start and cancel in the same idle cycle: nothing issues
    bus.op = MULT; bus.src1 = 32'd5; bus.src2 = 32'd6; bus.start = 1'b1; bus.cancel = 1'b1;
    @(negedge clk);
    bus.start = 1'b0; bus.cancel = 1'b0;
    chk("start_cancel_busy", W'(bus.busy), '0);
    repeat (5) @(negedge clk);

    // back-to-back: MULTU issued in the DONE cycle of a DIV
`ifdef MULDIV_DIV_EN
    start_op("b2b_div", DIVS, 32'd100, 32'd7, 32'd2, 32'd14, W + 1);
`else
    start_op("b2b_div", DIVS, 32'd100, 32'd7, 32'd0, 32'd0, 0);
`endif
    t = 0;
    do begin
      @(negedge clk); t++;
    end while (!bus.done && t < 60);
    if (!bus.done) begin
      n_cmp++; n_err++;
      $display("FAIL b2b_wait: done=%b, want 1", bus.done);
    end
    start_op("b2b_mul", MULTU, 32'd6, 32'd7, 32'd0, 32'd42, 2);
    drain("b2b_mul");

    // asynchronous reset mid-operation
`ifdef MULDIV_DIV_EN
    kick(DIVS, 32'd1000, 32'd3);
    repeat (5) @(negedge clk);
`else
    kick(MULT, 32'd5, 32'd5);
    @(negedge clk);
`endif
    resetn = 1'b0;
    #1;
    chk("arst_busy", W'(bus.busy), '0);
    chk("arst_done", W'(bus.done), '0);
    chk("arst_hi", bus.hi, '0);
    chk("arst_lo", bus.lo, '0);
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    mul("post_reset", MULT, 32'hFFFFFFFE, 32'd3, 32'hFFFFFFFF, 32'hFFFFFFFA);
    repeat (5) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
